// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: fetch FSM states,
// the NOP encoding and the machine word width.
package instr_fetch_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } fetch_state_e;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH entries of {instr, pc}, with synchronous clear.
// Storage is not reset; only the pointers and occupancy are.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             full;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (cnt == '0);
  assign full    = (cnt == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full buffer needs.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      mem[wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      if (do_push && !do_pop) begin
        cnt <= cnt + 1'b1;
      end else if (!do_push && do_pop) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  assign head_data = mem[rd_ptr];
  assign count     = cnt;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited in-order fetch with redirect flush.
// Optional build macro FETCH_MISALIGN_CHECK_EN adds the fetch_misalign output.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic        fetch_misalign,
`endif
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  input  logic        out_ready
);

  localparam int CNT_W = $clog2(DEPTH+1);

  fetch_state_e      state_q;
  fetch_state_e      state_d;
  logic [XLEN-1:0]   fetch_pc;
  logic [XLEN-1:0]   resp_pc;
  logic [XLEN-1:0]   target_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  stale;
  logic [CNT_W-1:0]  stale_n;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    inflight;
  logic [2*XLEN-1:0] head;
  logic              fifo_empty;
  logic              credit_ok;
  logic              fetch_halt;
  logic              grant;
  logic              rsp_any;
  logic              rsp_live;
  logic              push;
  logic              pop;

  assign target_pc = word_align(redirect_pc);

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      misalign_q <= 1'b0;
    end else if (redirect_valid) begin
      misalign_q <= |redirect_pc[1:0];
    end
  end

  assign fetch_halt     = misalign_q;
  assign fetch_misalign = misalign_q;
`else
  assign fetch_halt = 1'b0;
`endif

  assign inflight  = {1'b0, outstanding} + {1'b0, fifo_count};
  assign credit_ok = inflight < (CNT_W+1)'(DEPTH);
  assign grant     = imem_req && imem_gnt;

  // Responses are in order: while stale > 0 the oldest in-flight one is stale.
  assign rsp_any  = imem_rvalid && ((stale != '0) || (outstanding != '0));
  assign rsp_live = imem_rvalid && (stale == '0) && (outstanding != '0);
  assign push     = rsp_live && !redirect_valid;
  assign pop      = out_ready && !fifo_empty && !redirect_valid;

  always_comb begin
    stale_n = stale;
    if (redirect_valid) begin
      stale_n = outstanding + stale - CNT_W'(rsp_any);
    end else if (imem_rvalid && (stale != '0)) begin
      stale_n = stale - 1'b1;
    end
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_BOOT;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (redirect_valid) begin
      state_d = (stale_n != '0) ? ST_FLUSH : ST_RUN;
    end else begin
      case (state_q)
        ST_BOOT:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_RUN;
        ST_FLUSH: state_d = (stale_n == '0) ? ST_RUN : ST_FLUSH;
        default:  state_d = ST_BOOT;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    imem_req = 1'b0;
    if (state_q == ST_RUN) begin
      imem_req = !redirect_valid && !fetch_halt && credit_ok;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      stale       <= '0;
    end else begin
      stale <= stale_n;
      if (redirect_valid) begin
        fetch_pc    <= target_pc;
        resp_pc     <= target_pc;
        outstanding <= '0;
      end else begin
        if (grant) fetch_pc <= fetch_pc + 32'd4;
        if (push)  resp_pc  <= resp_pc + 32'd4;
        if (grant && !rsp_live) begin
          outstanding <= outstanding + 1'b1;
        end else if (!grant && rsp_live) begin
          outstanding <= outstanding - 1'b1;
        end
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (2*XLEN)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_valid),
    .push      (push),
    .push_data ({imem_rdata, resp_pc}),
    .pop       (pop),
    .head_data (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign imem_addr = fetch_pc;
  assign out_valid = !fifo_empty;
  assign out_instr = fifo_empty ? NOP_INSTR : head[2*XLEN-1:XLEN];
  assign out_pc    = fifo_empty ? '0 : head[XLEN-1:0];

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: two instances (RESET_PC 0 and FFFF_FFF8)
// each fed by an in-order one-cycle memory responder.
module tb_instr_fetch;

  localparam logic [31:0] KEY = 32'hDEAD_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        gnt;
  logic        out_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  bit          auto_resp;

  logic        a_req, a_rvalid, a_ovalid;
  logic [31:0] a_addr, a_rdata, a_oinstr, a_opc;
  logic        b_req, b_rvalid, b_ovalid;
  logic [31:0] b_addr, b_rdata, b_oinstr, b_opc;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic        a_mis, b_mis;
`endif

  logic [31:0] a_q[$];
  logic [31:0] b_q[$];

  int n_vec = 0;
  int n_err = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000), .DEPTH(2)) u_a (
    .clk(clk), .rst(rst),
`ifdef FETCH_MISALIGN_CHECK_EN
    .fetch_misalign(a_mis),
`endif
    .imem_req(a_req), .imem_addr(a_addr), .imem_gnt(gnt),
    .imem_rvalid(a_rvalid), .imem_rdata(a_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(a_ovalid), .out_instr(a_oinstr), .out_pc(a_opc),
    .out_ready(out_ready)
  );

  instr_fetch #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) u_b (
    .clk(clk), .rst(rst),
`ifdef FETCH_MISALIGN_CHECK_EN
    .fetch_misalign(b_mis),
`endif
    .imem_req(b_req), .imem_addr(b_addr), .imem_gnt(gnt),
    .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(b_ovalid), .out_instr(b_oinstr), .out_pc(b_opc),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, act, exp);
    end
  endtask

  // One clock: grants are sampled mid-cycle, responses driven after the edge.
  task automatic tick();
    bit          ga, gb;
    logic [31:0] aa, ab;
    @(negedge clk);
    ga = a_req && gnt;
    aa = a_addr;
    gb = b_req && gnt;
    ab = b_addr;
    @(posedge clk);
    #1;
    a_rvalid = 1'b0;
    b_rvalid = 1'b0;
    if (rst) begin
      a_q.delete();
      b_q.delete();
    end else begin
      if (ga) a_q.push_back(aa);
      if (gb) b_q.push_back(ab);
      if (auto_resp && a_q.size() > 0) begin
        a_rvalid = 1'b1;
        a_rdata  = a_q.pop_front() ^ KEY;
      end
      if (auto_resp && b_q.size() > 0) begin
        b_rvalid = 1'b1;
        b_rdata  = b_q.pop_front() ^ KEY;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 20 && !a_ovalid; i++) tick();
    chk(tag, {31'd0, a_ovalid}, 32'd1);
  endtask

  initial begin
    int          ga, gb, ngr, drops;
    bit          bad;
    logic [31:0] b_exp [3];
    b_exp[0] = 32'hFFFF_FFF8;
    b_exp[1] = 32'hFFFF_FFFC;
    b_exp[2] = 32'h0000_0000;

    rst = 1'b1; gnt = 1'b1; out_ready = 1'b1; auto_resp = 1'b1;
    redirect_valid = 1'b0; redirect_pc = '0;
    a_rvalid = 1'b0; a_rdata = '0; b_rvalid = 1'b0; b_rdata = '0;

    // Reset values, then streaming from RESET_PC on both instances
    tick(); tick();
    chk("rst_req", {31'd0, a_req}, 32'd0);
    chk("rst_addr", a_addr, 32'h0);
    chk("rst_b_addr", b_addr, 32'hFFFF_FFF8);
    chk("rst_valid", {31'd0, a_ovalid}, 32'd0);
    chk("rst_instr", a_oinstr, NOP);
    chk("rst_pc", a_opc, 32'h0);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("rst_misalign", {31'd0, a_mis}, 32'd0);
`endif
    rst = 1'b0;
    #1;
    chk("boot_req", {31'd0, a_req}, 32'd0);
    tick();
    chk("run_req", {31'd0, a_req}, 32'd1);
    chk("run_addr", a_addr, 32'h0);
    chk("lat_c1", {31'd0, a_ovalid}, 32'd0);
    tick();
    chk("lat_c2", {31'd0, a_ovalid}, 32'd0);
    tick();
    chk("lat_c3", {31'd0, a_ovalid}, 32'd1);
    ga = 0; gb = 0;
    for (int i = 0; i < 40 && (ga < 5 || gb < 3); i++) begin
      if (a_ovalid && ga < 5) begin
        chk($sformatf("seq_pc%0d", ga), a_opc, 32'(ga * 4));
        chk($sformatf("seq_instr%0d", ga), a_oinstr, 32'(ga * 4) ^ KEY);
        ga++;
      end
      if (b_ovalid && gb < 3) begin
        chk($sformatf("wrap_pc%0d", gb), b_opc, b_exp[gb]);
        gb++;
      end
      tick();
    end
    chk("seq_count", 32'(ga), 32'd5);
    chk("wrap_count", 32'(gb), 32'd3);

    // Back-pressure: credit limits grants to DEPTH, head held stable
    out_ready = 1'b0;
    do_reset();
    ngr = 0; bad = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (a_req && gnt) ngr++;
      if (a_ovalid && a_opc !== 32'h0) bad = 1'b1;
      tick();
    end
    chk("bp_grants", 32'(ngr), 32'd2);
    chk("bp_valid", {31'd0, a_ovalid}, 32'd1);
    chk("bp_pc", a_opc, 32'h0);
    chk("bp_stable", {31'd0, bad}, 32'd0);
    out_ready = 1'b1;
    tick();
    chk("bp_drain_pc", a_opc, 32'h4);

    // Redirect with two outstanding requests: both responses dropped
    out_ready = 1'b0;
    auto_resp = 1'b0;
    do_reset();
    tick(); tick(); tick(); tick();
    chk("fl_pending", 32'(a_q.size()), 32'd2);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0100;
    tick();
    redirect_valid = 1'b0;
    auto_resp = 1'b1;
    #1;
    chk("fl_req", {31'd0, a_req}, 32'd0);
    chk("fl_addr", a_addr, 32'h100);
    drops = 0; bad = 1'b0;
    for (int i = 0; i < 10 && !a_req; i++) begin
      if (a_rvalid) drops++;
      if (a_ovalid) bad = 1'b1;
      tick();
    end
    chk("fl_drops", 32'(drops), 32'd2);
    chk("fl_no_valid", {31'd0, bad}, 32'd0);
    out_ready = 1'b1;
    wait_valid("fl_timeout");
    chk("fl_pc", a_opc, 32'h100);
    chk("fl_instr", a_oinstr, 32'h100 ^ KEY);

    // Redirect, pop and response all in one cycle
    do_reset();
    tick(); tick(); tick();
    chk("same_pre_valid", {31'd0, a_ovalid}, 32'd1);
    chk("same_pre_rvalid", {31'd0, a_rvalid}, 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0300;
    #1;
    chk("same_req", {31'd0, a_req}, 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("same_valid", {31'd0, a_ovalid}, 32'd0);
    wait_valid("same_timeout");
    chk("same_pc", a_opc, 32'h300);

    // Low bits of a redirect target
    do_reset();
    tick(); tick(); tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    #1;
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_set", {31'd0, a_mis}, 32'd1);
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (a_req || a_ovalid) bad = 1'b1;
      tick();
    end
    chk("mis_idle", {31'd0, bad}, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("mis_clear", {31'd0, a_mis}, 32'd0);
    wait_valid("mis_timeout");
    chk("mis_pc", a_opc, 32'h200);
`else
    chk("align_addr", a_addr, 32'h100);
    wait_valid("align_timeout");
    chk("align_pc", a_opc, 32'h100);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 2: fetch-buffer entries; legal range 2..8.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 imem_req  output  1  fetch request valid.
REQ-006 imem_addr  output  32  word-aligned fetch address.
REQ-007 imem_gnt  input  1  request accepted this cycle when imem_req && imem_gnt.
REQ-008 imem_rvalid  input  1  read data valid; in-order, at least 1 cycle after grant.
REQ-009 imem_rdata  input  32  instruction word.
REQ-010 redirect_valid  input  1  branch/jump/trap redirect from execute.
REQ-011 redirect_pc  input  32  redirect target.
REQ-012 out_valid  output  1  instruction available to decode.
REQ-013 out_instr  output  32  instruction word to decode.
REQ-014 out_pc  output  32  PC of out_instr.
REQ-015 out_ready  input  1  decode accepts when out_valid && out_ready.

Function
REQ-016 FSM states: BOOT, RUN, FLUSH.
REQ-017 BOOT lasts exactly one cycle after reset release, then RUN; no request in BOOT.
REQ-018 RUN: imem_req=1 iff (outstanding + buffered) < DEPTH; imem_addr=fetch_pc.
REQ-019 On grant, fetch_pc += 4 (mod 2^32, wraps 32'hFFFF_FFFC -> 0) and outstanding += 1.
REQ-020 On imem_rvalid (not stale), {imem_rdata, pc} pushed to FIFO; outstanding -= 1.
REQ-021 FIFO head drives out_instr/out_pc; out_valid = FIFO not empty; no combinational path rvalid->out_valid (min latency grant->out_valid = 2 cycles).
REQ-022 Simultaneous push and pop when full-minus-credit permitted; occupancy unchanged.
REQ-023 redirect_valid (any state) in cycle N: FIFO cleared, out_valid=0 in N+1, fetch_pc=redirect_pc; stale count = outstanding (including a grant in cycle N); imem_req=0 in cycle N.
REQ-024 Data arriving in cycle N with redirect is discarded.
REQ-025 If stale count > 0, go FLUSH; else RUN. FLUSH: imem_req=0, each rvalid decrements stale and is dropped; stale=0 -> RUN.
REQ-026 redirect during FLUSH: new target replaces fetch_pc, stale count unchanged plus any new grant (none possible).
REQ-027 redirect takes priority over out_ready pop in same cycle.
REQ-028 out_instr/out_pc held stable while out_valid && !out_ready.

Reset
REQ-029 Reset values: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=32'h0000_0013 (NOP), out_pc=0, state=BOOT, fetch_pc=RESET_PC, counters=0.
REQ-030 Reset mid-operation discards FIFO and stale count; responses after reset for pre-reset requests are the environment's responsibility (memory reset alongside).

Configuration
REQ-031 Macro FETCH_MISALIGN_CHECK_EN: when defined, adds output fetch_misalign (1 bit, reset 0); a redirect_pc with [1:0]!=0 sets it, holds fetch idle (imem_req=0), cleared only by next aligned redirect or rst.
REQ-032 Without FETCH_MISALIGN_CHECK_EN: port absent; redirect_pc[1:0] ignored (forced to 2'b00).

Structure
REQ-033 Shared package: fetch FSM state enum, NOP encoding constant, XLEN=32.
REQ-034 One sub-module fetch_fifo (DEPTH x 64-bit, push/pop/clear, count output); FSM and counters in instr_fetch.

Verification
REQ-035 Reset, gnt=1, rvalid 1 cycle after grant, out_ready=1 -> out_pc 0,4,8,... with first out_valid 3 cycles after rst deassert.
REQ-036 out_ready=0 for 10 cycles -> exactly DEPTH(2) grants, out_valid held, out_pc stable at 0.
REQ-037 Redirect to 32'h0000_0100 with 2 outstanding -> 2 rvalids dropped, FLUSH exit, next out_pc=32'h100.
REQ-038 RESET_PC=32'hFFFF_FFF8 -> out_pc FFFF_FFF8, FFFF_FFFC, 0000_0000.
REQ-039 Redirect and out_ready same cycle as rvalid -> data dropped, out_valid=0 next cycle.
REQ-040 With FETCH_MISALIGN_CHECK_EN, redirect to 32'h0000_0102 -> fetch_misalign=1, imem_req=0; redirect to 32'h200 -> cleared, fetch resumes at 32'h200.
